gpr_file_sb: RTL and testbench

Parametrised general-purpose register file with N combinational read ports, one write port, same-cycle write-to-read forwarding, and an integrated per-register busy scoreboard. It is the next-generation register file for the pipelined datapath. Decode issues destination reservations. Writeback clears them. The read ports report both data and busy status so hazard logic can stall.

---
 rtl/gpr_file_sb.sv | 144 ++++++++++++++
 tb/tb_gpr_file_sb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - register file with write forwarding and busy scoreboard
//
// Purpose:
//   General-purpose register file with NUM_RD combinational read ports and
//   one write port. A write is forwarded to any read port that reads the
//   same address in the same cycle. A busy bit per register tracks pending
//   producers. Decode sets a bit through the issue port, and writeback
//   clears it. Each read port reports the data and the busy state, so
//   hazard logic can stall.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   rd_addr   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy   per-port busy flag of the addressed register
//   we        write enable
//   wr_addr   write address
//   wr_data   write data
//   iss_en    reserve a destination register
//   iss_addr  register to reserve
//   busy_cnt  number of registers currently busy (registered)
//   sb_full   every writable register is busy (registered)

module gpr_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [ADDR_W:0]            busy_cnt,
    output logic                       sb_full
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int FULL_I = DEPTH - ZERO_REG;
    localparam logic [ADDR_W:0] FULL_CNT = FULL_I[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;

    logic wr_legal;
    logic iss_legal;
    logic cnt_inc;
    logic cnt_dec;

    // The rst term keeps forwarding from leaking through while the array is
    // held in reset. During reset, all reads must return zero and not busy.
    assign wr_legal  = !rst && we &&
                       !((ZERO_REG != 0) && (wr_addr == '0));
    assign iss_legal = !rst && iss_en &&
                       !((ZERO_REG != 0) && (iss_addr == '0));

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              is_zero;
            logic              hit_wr;
            logic              hit_iss;

            assign ra      = rd_addr[k*ADDR_W +: ADDR_W];
            assign is_zero = (ZERO_REG != 0) && (ra == '0);
            assign hit_wr  = wr_legal && (wr_addr == ra);
            assign hit_iss = iss_legal && (iss_addr == ra);

            assign rd_data[k*DATA_W +: DATA_W] =
                (rst || is_zero) ? '0 :
                hit_wr           ? wr_data :
                                   mem[ra];

            // A completing writeback hides the busy bit in the same cycle.
            // A new issue to the same register keeps it busy, because the
            // newer producer is still outstanding.
            assign rd_busy[k] = !rst && !is_zero && busy[ra] &&
                                !(hit_wr && !hit_iss);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_legal) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------
    // The set is applied after the clear, so that an issue wins a collision
    // with a writeback to the same register.
    always_comb begin
        busy_nxt = busy;
        if (wr_legal) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (iss_legal) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    // The count tracks only real 0->1 and 1->0 transitions. An issue to a
    // busy register, or a write to an idle one, leaves the count unchanged.
    assign cnt_inc = iss_legal && !busy[iss_addr];
    assign cnt_dec = wr_legal && busy[wr_addr] &&
                     !(iss_legal && (iss_addr == wr_addr));

    assign cnt_nxt = busy_cnt + {{ADDR_W{1'b0}}, cnt_inc}
                              - {{ADDR_W{1'b0}}, cnt_dec};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            sb_full  <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            sb_full  <= (cnt_nxt == FULL_CNT);
        end
    end

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb/tb_gpr_file_sb.sv - self-checking bench for gpr_file_sb

module tb_gpr_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra0, ra1;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [5:0]  busy_cnt;
    logic        sb_full;

    int checks   = 0;
    int failures = 0;

    // Reference state: the architectural contents and pending-producer set.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    assign rd_addr = {ra1, ra0};

    always #5 clk = ~clk;

    gpr_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt),
        .sb_full(sb_full)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit w_ok();
        return !rst && we && (wr_addr != 5'd0);
    endfunction

    function automatic bit i_ok();
        return !rst && iss_en && (iss_addr != 5'd0);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        if (w_ok() && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (rst || a == 5'd0) return 1'b0;
        if (w_ok() && wr_addr == a && !(i_ok() && iss_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_comb(input string tag);
        chk({tag, ".rd_data0"}, {32'd0, rd_data[31:0]},  {32'd0, exp_data(ra0)});
        chk({tag, ".rd_data1"}, {32'd0, rd_data[63:32]}, {32'd0, exp_data(ra1)});
        chk({tag, ".rd_busy0"}, {63'd0, rd_busy[0]}, {63'd0, exp_busy(ra0)});
        chk({tag, ".rd_busy1"}, {63'd0, rd_busy[1]}, {63'd0, exp_busy(ra1)});
    endtask

    task automatic check_regs(input string tag);
        int n = m_count();
        chk({tag, ".busy_cnt"}, {58'd0, busy_cnt}, 64'(n));
        chk({tag, ".sb_full"}, {63'd0, sb_full}, {63'd0, n == 31});
    endtask

    // One clock cycle. The inputs are applied just after an edge, and the
    // combinational outputs are checked mid-cycle. The edge is then taken,
    // and the registered outputs are checked just after it.
    task automatic cycle(input string tag, input logic [4:0] a0,
                         input logic [4:0] a1, input logic w,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia);
        bit wl, il;
        ra0 = a0; ra1 = a1; we = w; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia;
        #2;
        check_comb(tag);
        wl = w_ok();
        il = i_ok();
        @(posedge clk);
        if (wl) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (il) m_busy[ia] = 1'b1;
        #1;
        check_regs(tag);
    endtask

    initial begin
        rst = 1'b1;
        ra0 = 5'd0; ra1 = 5'd0; we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        iss_en = 1'b0; iss_addr = 5'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        ra0 = 5'd5; ra1 = 5'd31;
        #1;
        check_comb("reset");
        check_regs("reset");
        rst = 1'b0;

        // Asynchronous reset in the middle of operation.
        cycle("w5", 5'd5, 5'd6, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6);
        cycle("rd5", 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'h55; iss_en = 1'b1; iss_addr = 5'd7;
        #1;
        rst = 1'b1;
        m_reset();
        #1;
        check_comb("async_rst");
        check_regs("async_rst");
        @(posedge clk);
        #1;
        check_regs("rst_edge");
        rst = 1'b0;
        cycle("post_rst", 5'd5, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Both ports forward the same write.
        cycle("fwd", 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
        cycle("fwd_mem", 5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // A write and an issue to the zero register are ignored.
        cycle("zero", 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
        cycle("zero_after", 5'd0, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Issue r3, then write r3 back.
        cycle("iss3", 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cycle("busy3", 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cycle("wb3", 5'd3, 5'd3, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0);
        cycle("idle3", 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // An issue and a writeback to r9 in the same cycle, with r9 busy.
        cycle("iss9", 5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        cycle("coll9", 5'd9, 5'd9, 1'b1, 5'd9, 32'hCAFE0009, 1'b1, 5'd9);
        cycle("after9", 5'd9, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Fill the scoreboard, then issue and write in the same cycle.
        for (int i = 1; i < 32; i++)
            cycle($sformatf("fill%0d", i), 5'(i), 5'(i - 1), 1'b0, 5'd0, 32'd0,
                  1'b1, 5'(i));
        cycle("full_iss", 5'd4, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        cycle("swap", 5'd2, 5'd4, 1'b1, 5'd2, 32'h00000002, 1'b1, 5'd4);
        cycle("unfull", 5'd2, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++)
            cycle("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));

        // A second reset that discards a pending write and a pending issue.
        we = 1'b1; wr_addr = 5'd12; wr_data = 32'h77; iss_en = 1'b1; iss_addr = 5'd13;
        #1;
        rst = 1'b1;
        m_reset();
        #1;
        check_regs("rst2");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 40; n++)
            cycle("rand2", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
